// File: rtl/ifetch_queue_pkg.sv
// rtl/ifetch_queue_pkg.sv - shared constants for the instruction fetch queue
package ifetch_queue_pkg;

  // Instruction word width; each queue entry is {pc, instruction}
  localparam int INSTR_W = 32;

  // Sequential fetch stride in bytes
  localparam logic [INSTR_W-1:0] PC_INC = 32'd4;

  // First fetch address after reset unless the instance overrides it
  localparam logic [INSTR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Fetch FSM encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

endpackage

// File: rtl/iq_fifo.sv
// rtl/iq_fifo.sv - instruction queue storage with push/pop/flush and occupancy count
module iq_fifo
  import ifetch_queue_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W = 2 * INSTR_W,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Head is read combinationally; storage resets to zero so the head reads 0 in reset
  assign rdata = mem[rd_ptr];

  // Pointer, count and storage update; flush empties the queue without touching storage.
  // A push and pop at full write the slot being vacated, which is then the newest entry.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - sequential instruction fetcher feeding a small decode queue
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         redirect,
  input  logic [31:0]  redirect_pc,
  output logic         m_en,
  output logic         m_rw,
  output logic [31:0]  mar,
  input  logic         m_ready,
  input  logic [31:0]  dbus,
  output logic         ir_valid,
  output logic [31:0]  ir,
  output logic [31:0]  ir_pc,
  input  logic         ir_ready
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [1:0]           state;
  logic [1:0]           state_next;
  logic [31:0]          fetch_pc;
  logic [31:0]          fetch_pc_next;
  logic [CW-1:0]        count;
  logic [CW-1:0]        count_next;
  logic                 accept;
  logic                 pop;
  logic [2*INSTR_W-1:0] head;

  // Redirect discards both the in-flight response and any pop in its cycle
  assign m_rw     = 1'b1;
  assign accept   = m_en & m_ready & ~redirect;
  assign pop      = ir_valid & ir_ready & ~redirect;
  assign ir_valid = (count != '0);
  assign ir_pc    = head[2*INSTR_W-1:INSTR_W];
  assign ir       = head[INSTR_W-1:0];

  // Occupancy after this edge; drives the FETCH/FULL decision
  always_comb begin
    count_next = count;
    if (redirect) begin
      count_next = '0;
    end else if (accept && !pop) begin
      count_next = count + CW'(1);
    end else if (pop && !accept) begin
      count_next = count - CW'(1);
    end
  end

  // Next fetch address: word-aligned redirect target, or advance past an accepted word
  always_comb begin
    fetch_pc_next = fetch_pc;
    if (redirect) begin
      fetch_pc_next = redirect_pc & ~32'h3;
    end else if (accept) begin
      fetch_pc_next = fetch_pc + PC_INC;
    end
  end

  // Leave IDLE on the first edge; afterwards fetch whenever the queue will have room
  always_comb begin
    state_next = ST_FETCH;
    case (state)
      ST_IDLE: state_next = ST_FETCH;
      default: state_next = (count_next < DEPTH_C) ? ST_FETCH : ST_FULL;
    endcase
  end

  // Registered memory request; mar always mirrors the pending fetch address
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      fetch_pc <= RESET_PC;
      mar      <= RESET_PC;
      m_en     <= 1'b0;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      mar      <= fetch_pc_next;
      m_en     <= (state_next == ST_FETCH);
    end
  end

  iq_fifo #(
    .DEPTH (DEPTH),
    .W     (2 * INSTR_W)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (accept),
    .pop   (pop),
    .flush (redirect),
    .wdata ({fetch_pc, dbus}),
    .rdata (head),
    .count (count)
  );

endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - directed table-driven bench for ifetch_queue
module tb_ifetch_queue;

  logic        clock;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        m_en;
  logic        m_rw;
  logic [31:0] mar;
  logic        m_ready;
  logic [31:0] dbus;
  logic        ir_valid;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic        ir_ready;

  int tests;
  int fails;

  typedef struct {
    logic        rst;
    logic        rd;
    logic [31:0] rpc;
    logic        mr;
    logic        irr;
    logic        e_en;
    logic [31:0] e_mar;
    logic        e_v;
    logic        ck;
    logic [31:0] e_ir;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[$];

  ifetch_queue #(.DEPTH(2), .RESET_PC(32'h0)) dut (
    .clock       (clock),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .m_en        (m_en),
    .m_rw        (m_rw),
    .mar         (mar),
    .m_ready     (m_ready),
    .dbus        (dbus),
    .ir_valid    (ir_valid),
    .ir          (ir),
    .ir_pc       (ir_pc),
    .ir_ready    (ir_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h001F0018;
      32'h4:   return 32'h002F0010;
      32'h8:   return 32'h003F0014;
      default: return a ^ 32'hA5A50000;
    endcase
  endfunction

  assign dbus = mem_word(mar);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic row(input logic rst, input logic rd, input logic [31:0] rpc,
                     input logic mr, input logic irr, input logic e_en,
                     input logic [31:0] e_mar, input logic e_v, input logic ck,
                     input logic [31:0] e_ir, input logic [31:0] e_pc);
    vec_t v;
    v.rst = rst; v.rd = rd; v.rpc = rpc; v.mr = mr; v.irr = irr;
    v.e_en = e_en; v.e_mar = e_mar; v.e_v = e_v; v.ck = ck;
    v.e_ir = e_ir; v.e_pc = e_pc;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    redirect = 1'b0;
    redirect_pc = '0;
    m_ready = 1'b0;
    ir_ready = 1'b0;

    // rst rd rpc mr irr | m_en mar valid | chk ir ir_pc
    // straight-line fetch after reset
    row(0, 0, 32'h0, 0, 0,  0, 32'h0, 0,  1, 32'h0, 32'h0);
    row(1, 0, 32'h0, 1, 1,  1, 32'h0, 0,  0, 32'h0, 32'h0);
    row(1, 0, 32'h0, 1, 1,  1, 32'h4, 1,  1, 32'h001F0018, 32'h0);
    row(1, 0, 32'h0, 1, 1,  1, 32'h8, 1,  1, 32'h002F0010, 32'h4);
    row(1, 0, 32'h0, 1, 1,  1, 32'hC, 1,  1, 32'h003F0014, 32'h8);
    // decode stall fills the queue, then resumes without skipping
    row(0, 0, 32'h0, 1, 1,  0, 32'h0, 0,  1, 32'h0, 32'h0);
    row(1, 0, 32'h0, 1, 0,  1, 32'h0, 0,  0, 32'h0, 32'h0);
    row(1, 0, 32'h0, 1, 0,  1, 32'h4, 1,  1, 32'h001F0018, 32'h0);
    row(1, 0, 32'h0, 1, 0,  0, 32'h8, 1,  1, 32'h001F0018, 32'h0);
    row(1, 0, 32'h0, 1, 0,  0, 32'h8, 1,  1, 32'h001F0018, 32'h0);
    row(1, 0, 32'h0, 1, 0,  0, 32'h8, 1,  1, 32'h001F0018, 32'h0);
    row(1, 0, 32'h0, 1, 0,  0, 32'h8, 1,  1, 32'h001F0018, 32'h0);
    row(1, 0, 32'h0, 1, 1,  1, 32'h8, 1,  1, 32'h002F0010, 32'h4);
    row(1, 0, 32'h0, 1, 1,  1, 32'hC, 1,  1, 32'h003F0014, 32'h8);
    row(1, 0, 32'h0, 1, 1,  1, 32'h10, 1, 1, 32'hA5A5000C, 32'hC);
    // redirect with two entries queued
    row(0, 0, 32'h0, 0, 0,  0, 32'h0, 0,  1, 32'h0, 32'h0);
    row(1, 0, 32'h0, 1, 0,  1, 32'h0, 0,  0, 32'h0, 32'h0);
    row(1, 0, 32'h0, 1, 0,  1, 32'h4, 1,  1, 32'h001F0018, 32'h0);
    row(1, 0, 32'h0, 1, 0,  0, 32'h8, 1,  1, 32'h001F0018, 32'h0);
    row(1, 1, 32'hE, 1, 1,  1, 32'hC, 0,  0, 32'h0, 32'h0);
    row(1, 0, 32'h0, 1, 0,  1, 32'h10, 1, 1, 32'hA5A5000C, 32'hC);
    // memory wait states hold the request
    row(0, 0, 32'h0, 0, 0,  0, 32'h0, 0,  1, 32'h0, 32'h0);
    row(1, 0, 32'h0, 1, 1,  1, 32'h0, 0,  0, 32'h0, 32'h0);
    row(1, 0, 32'h0, 1, 1,  1, 32'h4, 1,  1, 32'h001F0018, 32'h0);
    row(1, 0, 32'h0, 0, 1,  1, 32'h4, 0,  0, 32'h0, 32'h0);
    row(1, 0, 32'h0, 0, 1,  1, 32'h4, 0,  0, 32'h0, 32'h0);
    row(1, 0, 32'h0, 0, 1,  1, 32'h4, 0,  0, 32'h0, 32'h0);
    row(1, 0, 32'h0, 1, 1,  1, 32'h8, 1,  1, 32'h002F0010, 32'h4);
    // address wrap at the top of memory
    row(1, 1, 32'hFFFFFFFC, 1, 1,  1, 32'hFFFFFFFC, 0,  0, 32'h0, 32'h0);
    row(1, 0, 32'h0, 1, 1,  1, 32'h0, 1,  1, 32'h5A5AFFFC, 32'hFFFFFFFC);
    row(1, 0, 32'h0, 1, 1,  1, 32'h4, 1,  1, 32'h001F0018, 32'h0);

    #1;
    foreach (vecs[i]) begin
      reset       = vecs[i].rst;
      redirect    = vecs[i].rd;
      redirect_pc = vecs[i].rpc;
      m_ready     = vecs[i].mr;
      ir_ready    = vecs[i].irr;
      tick();
      check($sformatf("row%0d m_en", i), {31'b0, m_en}, {31'b0, vecs[i].e_en});
      check($sformatf("row%0d mar", i), mar, vecs[i].e_mar);
      check($sformatf("row%0d ir_valid", i), {31'b0, ir_valid}, {31'b0, vecs[i].e_v});
      check($sformatf("row%0d m_rw", i), {31'b0, m_rw}, 32'h1);
      if (vecs[i].ck) begin
        check($sformatf("row%0d ir", i), ir, vecs[i].e_ir);
        check($sformatf("row%0d ir_pc", i), ir_pc, vecs[i].e_pc);
      end
    end
    redirect = 1'b0;

    // reset dropped mid-request while memory is stalled
    m_ready = 1'b0;
    tick();
    check("stall m_en", {31'b0, m_en}, 32'h1);
    check("stall mar", mar, 32'h4);
    #2;
    reset = 1'b0;
    #1;
    check("async m_en", {31'b0, m_en}, 32'h0);
    check("async mar", mar, 32'h0);
    check("async ir_valid", {31'b0, ir_valid}, 32'h0);
    check("async ir", ir, 32'h0);
    check("async ir_pc", ir_pc, 32'h0);
    check("async m_rw", {31'b0, m_rw}, 32'h1);
    m_ready = 1'b1;
    @(negedge clock);
    tick();
    check("held ir_valid", {31'b0, ir_valid}, 32'h0);
    check("held m_en", {31'b0, m_en}, 32'h0);
    reset = 1'b1;
    tick();
    check("restart m_en", {31'b0, m_en}, 32'h1);
    check("restart mar", mar, 32'h0);
    tick();
    check("restart ir_valid", {31'b0, ir_valid}, 32'h1);
    check("restart ir_pc", ir_pc, 32'h0);
    check("restart ir", ir, 32'h001F0018);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 The block SHALL take parameter DEPTH, default 2, meaning the number of instruction-queue entries (legal values 2 or 4).
REQ-002 The block SHALL take parameter RESET_PC, default 32'h00000000, meaning the first fetch address after reset.
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port redirect, input, 1 bit: a taken jump/branch from downstream; flushes the queue.
REQ-006 The block SHALL have port redirect_pc, input, 32 bits: the new fetch address, valid while redirect=1.
REQ-007 The block SHALL have port m_en, output, 1 bit: memory request enable.
REQ-008 The block SHALL have port m_rw, output, 1 bit: fixed at 1 (read).
REQ-009 The block SHALL have port mar, output, 32 bits: memory byte address.
REQ-010 The block SHALL have port m_ready, input, 1 bit: memory has valid data on dbus this cycle.
REQ-011 The block SHALL have port dbus, input, 32 bits: the instruction word read from memory.
REQ-012 The block SHALL have port ir_valid, output, 1 bit: the queue head is valid.
REQ-013 The block SHALL have port ir, output, 32 bits: the instruction at the queue head.
REQ-014 The block SHALL have port ir_pc, output, 32 bits: the address of the instruction at the queue head.
REQ-015 The block SHALL have port ir_ready, input, 1 bit: decode consumes the head this cycle; deasserted means stall.

Function
REQ-016 The FSM SHALL have states IDLE, FETCH and FULL.
REQ-017 The FSM SHALL go from IDLE to FETCH on the first edge after reset deasserts.
REQ-018 The FSM SHALL be in FETCH whenever count_next < DEPTH, and otherwise in FULL.
REQ-019 The block SHALL register m_en and mar, and SHALL drive m_en=1 only in FETCH, with mar = fetch_pc.
REQ-020 A response SHALL be accepted at an edge where m_en=1, m_ready=1 and redirect=0; acceptance pushes {fetch_pc, dbus} and sets fetch_pc to fetch_pc+4, modulo 2^32 (32'hFFFFFFFC wraps to 0).
REQ-021 While m_en=1 and m_ready=0, the block SHALL hold mar and m_en stable.
REQ-022 A pop SHALL occur at an edge where ir_valid=1, ir_ready=1 and redirect=0.
REQ-023 The outputs SHALL be ir_valid = (count != 0), and ir/ir_pc = the head entry; ir and ir_pc are don't-care when ir_valid=0.
REQ-024 A simultaneous push and pop SHALL leave count unchanged, and this SHALL be legal when count = DEPTH.
REQ-025 At a full queue with a pop and no push, m_en SHALL rise on the following edge.
REQ-026 Redirect SHALL take priority over every other event.
REQ-027 On a redirect edge the block SHALL empty the queue (count=0, pointers reset), set fetch_pc = {redirect_pc[31:2], 2'b00}, set mar to that value with m_en=1, and discard any response and pop in the same cycle.
REQ-028 Latency from reset deassertion SHALL be as follows: m_en=1 with mar=RESET_PC after the first edge; with m_ready=1, ir_valid=1 after the second edge.
REQ-029 Latency after a redirect SHALL be as follows: with m_ready=1, ir_valid=1 with ir_pc=redirect_pc one edge after the redirect edge.
REQ-030 Steady-state throughput SHALL be 1 instruction per cycle when m_ready=1 and ir_ready=1.

Reset
REQ-031 While reset=0, the block SHALL asynchronously force: state=IDLE, fetch_pc=RESET_PC, mar=RESET_PC, m_en=0, count=0, ir_valid=0, ir=0, ir_pc=0.
REQ-032 Reset asserted mid-request SHALL abandon the request, and no entry SHALL be pushed.
REQ-033 m_rw SHALL be 1 in all states, including during reset.

Structure
REQ-034 A shared package SHALL hold the FSM state encoding, the instruction width (32), the PC increment (4) and the default RESET_PC.
REQ-035 Queue storage SHALL be a separate sub-module, iq_fifo (DEPTH entries of 64 bits, with push/pop/flush inputs and count), instantiated once.

Verification
REQ-036 The bench SHALL run this scenario: memory preloaded with 001F0018 at 0, 002F0010 at 4, 003F0014 at 8; m_ready=1, ir_ready=1; release reset -> ir/ir_pc pairs 001F0018/0, 002F0010/4, 003F0014/8 on consecutive cycles, starting 2 edges after release.
REQ-037 The bench SHALL run this scenario: ir_ready=0 for 5 cycles -> m_en falls after the queue holds DEPTH entries, ir stays 001F0018, no address is skipped after ir_ready returns to 1.
REQ-038 The bench SHALL run this scenario: redirect=1 with redirect_pc=0000000E while 2 entries are queued -> next edge count=0 and mar=0000000C; one edge later ir_pc=0000000C.
REQ-039 The bench SHALL run this scenario: m_ready held 0 for 3 cycles -> mar stable at 00000004 and ir_valid=0 once the queue drains; m_ready=1 -> entry pushed with ir_pc=00000004.
REQ-040 The bench SHALL run this scenario: redirect to FFFFFFFC with m_ready=1 -> ir_pc sequence FFFFFFFC then 00000000.
REQ-041 The bench SHALL run this scenario: reset pulled low mid-request with m_ready=0 -> outputs reach their reset values immediately, before the next clock edge; after release, fetch restarts at RESET_PC.
